// File: rtl/aes_pkg.sv
// Shared AES types and helpers; this slice holds the entropy arbiter state
// encoding and its index-width helper.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_ACK = 2'b01,
        DELIVER  = 2'b10
    } aes_entropy_arb_e;

    // Index width for NumReq channels; a single channel still needs one bit.
    function automatic int entropy_arb_idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/aes_entropy_rr_pick.sv
// Combinational request picker: lowest set index in fixed mode, or the first
// set index after i_ptr (cyclically) in round-robin mode.
module aes_entropy_rr_pick #(
    parameter int NumReq = 2,
    parameter int IdxW   = 1
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IdxW-1:0]   i_ptr,
    input  logic              i_rr_mode,
    output logic [IdxW-1:0]   o_idx,
    output logic              o_valid
);

    logic [IdxW-1:0] w_cand;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        if (i_rr_mode && (NumReq > 1)) begin
            for (int k = 1; k <= NumReq; k++) begin
                w_cand = IdxW'((int'(i_ptr) + k) % NumReq);
                if (!o_valid && i_req[w_cand]) begin
                    o_valid = 1'b1;
                    o_idx   = w_cand;
                end
            end
        end else begin
            // Scan downwards so the lowest set index is the last one written.
            for (int j = NumReq - 1; j >= 0; j--) begin
                if (i_req[j]) begin
                    o_valid = 1'b1;
                    o_idx   = IdxW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/aes_entropy_arb.sv
// Shares one EDN entropy source among NumReq consumers: one locked grant per
// word, registered delivery, wait-timeout monitor and sticky protocol flags.
module aes_entropy_arb
    import aes_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int Width         = 32,
    parameter bit RoundRobin    = 1'b0,
    parameter int TimeoutCycles = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] ack_o,
    output logic [Width-1:0]  data_o,
    output logic              edn_req_o,
    input  logic              edn_ack_i,
    input  logic [Width-1:0]  edn_data_i,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              timeout_o,
    output logic              spurious_ack_o,
    output logic              drop_o
);

    localparam int EntropyArbIdxW = entropy_arb_idx_w(NumReq);

    aes_entropy_arb_e            r_state;
    logic [EntropyArbIdxW-1:0]   r_grant;
    logic [Width-1:0]            r_data;
    logic [NumReq-1:0]           r_ack;
    logic                        r_drop;
    logic                        r_edn_req;
    logic                        r_busy;
    logic                        r_timeout;
    logic                        r_spurious;

    logic [EntropyArbIdxW-1:0]   w_ptr;
    logic [EntropyArbIdxW-1:0]   w_pick_idx;
    logic                        w_pick_valid;

    aes_entropy_rr_pick #(
        .NumReq (NumReq),
        .IdxW   (EntropyArbIdxW)
    ) u_pick (
        .i_req     (req_i),
        .i_ptr     (w_ptr),
        .i_rr_mode (RoundRobin),
        .o_idx     (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    if ((NumReq > 1) && RoundRobin) begin : g_ptr
        logic [EntropyArbIdxW-1:0] r_ptr;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_ptr <= EntropyArbIdxW'(NumReq - 1);
            end else if ((r_state == IDLE) && w_pick_valid) begin
                r_ptr <= w_pick_idx;
            end
        end

        assign w_ptr = r_ptr;
    end else begin : g_no_ptr
        assign w_ptr = EntropyArbIdxW'(NumReq - 1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            // NOTE: the entropy word is reset too, so nothing captured before a reset survives it.
            r_data    <= '0;
            r_ack     <= '0;
            r_drop    <= 1'b0;
            r_edn_req <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // NOTE: strobes default low here and are raised below; with <= the last write wins.
            r_ack  <= '0;
            r_drop <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant   <= w_pick_idx;
                        r_state   <= WAIT_ACK;
                        r_edn_req <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // Grant stays locked and the upstream request is held until the ack.
                    if (edn_ack_i) begin
                        r_data    <= edn_data_i;
                        r_edn_req <= 1'b0;
                        r_state   <= DELIVER;
                        if (req_i[r_grant]) begin
                            r_ack[r_grant] <= 1'b1;
                        end else begin
                            r_drop <= 1'b1;
                        end
                    end
                end
                DELIVER: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_edn_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    if (TimeoutCycles > 0) begin : g_timeout
        localparam int CntW = $clog2(TimeoutCycles + 1);
        logic [CntW-1:0] r_cnt;
        logic [CntW-1:0] w_cnt_inc;

        assign w_cnt_inc = r_cnt + 1'b1;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_cnt     <= '0;
                r_timeout <= 1'b0;
            end else begin
                if ((r_state == IDLE) && w_pick_valid) begin
                    r_cnt <= '0;
                end else if ((r_state == WAIT_ACK) && (r_cnt != CntW'(TimeoutCycles))) begin
                    r_cnt <= w_cnt_inc;
                end
                // Flag as the count reaches the limit; the request itself keeps waiting.
                if ((r_state == WAIT_ACK) && (w_cnt_inc == CntW'(TimeoutCycles))) begin
                    r_timeout <= 1'b1;
                end else if (clear_i) begin
                    r_timeout <= 1'b0;
                end
            end
        end
    end else begin : g_no_timeout
        assign r_timeout = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_spurious <= 1'b0;
        end else if (edn_ack_i && (r_state != WAIT_ACK)) begin
            r_spurious <= 1'b1;
        end else if (clear_i) begin
            r_spurious <= 1'b0;
        end
    end

    assign ack_o          = r_ack;
    assign data_o         = (|r_ack) ? r_data : '0;
    assign edn_req_o      = r_edn_req;
    assign busy_o         = r_busy;
    assign timeout_o      = r_timeout;
    assign spurious_ack_o = r_spurious;
    assign drop_o         = r_drop;

endmodule
